// File: rtl/conv_pkg.sv
// Shared constants, puncture tables and FSM state type for the K=7 punctured encoder.
// Used by conv_core and conv_punct_encoder (optional zero tail: CONV_ZERO_TAIL_EN).
package conv_pkg;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;
    localparam logic [1:0] RATE_5_6 = 2'b11;

    // Generator taps over the window {in, sr[0], sr[1], ..., sr[5]}, in at the MSB
    localparam logic [6:0] G1 = 7'o171;
    localparam logic [6:0] G2 = 7'o133;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DRAIN = 2'd3
    } conv_state_e;

    function automatic logic [2:0] punct_period(input logic [1:0] rate);
        logic [2:0] p;
        unique case (rate)
            RATE_1_2: p = 3'd1;
            RATE_2_3: p = 3'd2;
            RATE_3_4: p = 3'd3;
            default:  p = 3'd5;
        endcase
        return p;
    endfunction

    // Returns {keep_x, keep_y} for the given puncture phase
    function automatic logic [1:0] punct_keep(input logic [1:0] rate, input logic [2:0] phase);
        logic [1:0] k;
        unique case (rate)
            RATE_1_2: k = 2'b11;
            RATE_2_3: k = (phase == 3'd0) ? 2'b11 : 2'b01;
            RATE_3_4: begin
                case (phase)
                    3'd0:    k = 2'b11;
                    3'd1:    k = 2'b01;
                    default: k = 2'b10;
                endcase
            end
            default: begin
                case (phase)
                    3'd0:    k = 2'b11;
                    3'd1:    k = 2'b01;
                    3'd2:    k = 2'b10;
                    3'd3:    k = 2'b01;
                    default: k = 2'b10;
                endcase
            end
        endcase
        return k;
    endfunction

endpackage

// File: rtl/conv_core.sv
// Mother-code core: 6-bit history register plus combinational X/Y generation.
module conv_core
    import conv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic x,
    output logic y
);

    logic [5:0] sr_q;
    logic [6:0] win;

    always_comb begin
        win = {din, sr_q[0], sr_q[1], sr_q[2], sr_q[3], sr_q[4], sr_q[5]};
        x   = ^(win & G1);
        y   = ^(win & G2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q <= '0;
        end else if (clr) begin
            sr_q <= '0;
        end else if (en) begin
            sr_q <= {sr_q[4:0], din};
        end
    end

endmodule

// File: rtl/conv_punct_encoder.sv
// Rate-1/2 K=7 encoder with 802.16 puncturing, ready/valid in and out.
// Define CONV_ZERO_TAIL_EN to flush TAIL_LEN zero bits after in_last.
//
// state    | meaning
// ST_IDLE  | waiting for start, input blocked
// ST_RUN   | accepting data bits
// ST_TAIL  | encoding internal zero flush bits, input blocked
// ST_DRAIN | emptying the buffer until the out_last bit is taken
module conv_punct_encoder
    import conv_pkg::*;
#(
    parameter int unsigned TAIL_LEN = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] rate,
    input  logic       in_bits,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_bits,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int unsigned TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN + 1) : 1;

    conv_state_e state, state_nxt;
    logic [1:0]    rate_q;
    logic [2:0]    phase;
    logic [1:0]    pending, pending_nxt;
    logic [1:0]    buf_bit, buf_bit_nxt;
    logic [1:0]    buf_last, buf_last_nxt;
    logic [TW-1:0] tail_cnt;

    logic       pop, can_push, enc_run, enc_tail, enc_en, enc_din, enc_last, tail_done;
    logic       x, y;
    logic [1:0] keep;

    conv_core u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (enc_en),
        .din   (enc_din),
        .x     (x),
        .y     (y)
    );

    assign out_valid = (pending != 2'd0);
    assign out_bits  = buf_bit[0];
    assign out_last  = buf_last[0] && out_valid;

    always_comb begin
        pop       = out_valid && out_ready;
        can_push  = (pending == 2'd0) || (pending == 2'd1 && pop);
        in_ready  = (state == ST_RUN) && !start && can_push;
        enc_run   = in_valid && in_ready;
        tail_done = (tail_cnt == TW'(1));
`ifdef CONV_ZERO_TAIL_EN
        enc_tail  = (state == ST_TAIL) && !start && can_push;
        enc_last  = enc_tail && tail_done;
`else
        enc_tail  = 1'b0;
        enc_last  = enc_run && in_last;
`endif
        enc_en    = enc_run || enc_tail;
        enc_din   = enc_run && in_bits;
        keep      = punct_keep(rate_q, phase);
    end

    // A push only happens once the buffer is empty after this cycle's pop, so it lands at entry 0
    always_comb begin
        buf_bit_nxt  = buf_bit;
        buf_last_nxt = buf_last;
        pending_nxt  = pending;
        if (pop) begin
            buf_bit_nxt  = {1'b0, buf_bit[1]};
            buf_last_nxt = {1'b0, buf_last[1]};
            pending_nxt  = pending - 2'd1;
        end
        if (enc_en) begin
            unique case (keep)
                2'b11: begin
                    buf_bit_nxt  = {y, x};
                    buf_last_nxt = {enc_last, 1'b0};
                    pending_nxt  = 2'd2;
                end
                2'b10: begin
                    buf_bit_nxt  = {1'b0, x};
                    buf_last_nxt = {1'b0, enc_last};
                    pending_nxt  = 2'd1;
                end
                default: begin
                    buf_bit_nxt  = {1'b0, y};
                    buf_last_nxt = {1'b0, enc_last};
                    pending_nxt  = 2'd1;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (enc_run && in_last) begin
`ifdef CONV_ZERO_TAIL_EN
                        state_nxt = ST_TAIL;
`else
                        state_nxt = ST_DRAIN;
`endif
                    end
                end
                ST_TAIL:  if (enc_tail && tail_done) state_nxt = ST_DRAIN;
                ST_DRAIN: if (pop && out_last) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rate_q   <= RATE_1_2;
            phase    <= '0;
            pending  <= '0;
            buf_bit  <= '0;
            buf_last <= '0;
            tail_cnt <= '0;
        end else if (start) begin
            state    <= state_nxt;
            rate_q   <= rate;
            phase    <= '0;
            pending  <= '0;
            buf_bit  <= '0;
            buf_last <= '0;
            tail_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            buf_bit  <= buf_bit_nxt;
            buf_last <= buf_last_nxt;
            if (enc_en) begin
                phase <= (phase == punct_period(rate_q) - 3'd1) ? 3'd0 : phase + 3'd1;
            end
            if (enc_run && in_last) begin
                tail_cnt <= TW'(TAIL_LEN);
            end else if (enc_tail) begin
                tail_cnt <= tail_cnt - TW'(1);
            end
        end
    end

endmodule

// File: doc/conv_punct_encoder.md
Name: conv_punct_encoder

Overview:
- Rate-1/2, K=7 convolutional encoder with 802.16 OFDM puncturing to rates 1/2, 2/3, 3/4 and 5/6.
- Sits directly downstream of the randomizer and consumes its serial bit stream.
- Emits a serial coded bit stream to the interleaver using a ready/valid handshake.
- Throttles its input with in_ready because punctured output exceeds one bit per input bit.

Parameters:
- TAIL_LEN, 6, number of zero flush bits injected after in_last (used only with CONV_ZERO_TAIL_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: clear the shift register and puncture phase, latch rate, abort any burst in progress.
- rate  in  2  code rate: 00=1/2, 01=2/3, 10=3/4, 11=5/6. Sampled only on start.
- in_bits  in  1  data bit from the randomizer.
- in_valid  in  1  in_bits is valid.
- in_last  in  1  marks the final bit of the burst.
- in_ready  out  1  encoder accepts in_bits this cycle.
- out_bits  out  1  coded bit.
- out_valid  out  1  out_bits is valid.
- out_ready  in  1  downstream accepts out_bits.
- out_last  out  1  marks the final coded bit of the burst.

Behaviour:
- Reset (reset==0 at posedge): all outputs 0, shift register sr[5:0]=0, phase=0, pending=0, latched rate=00, state=IDLE.
- States:
  - IDLE: in_ready=0 until start.
  - start moves to RUN.
  - In RUN, accepting a bit with in_last moves to TAIL (with the macro) or DRAIN (without it).
  - TAIL moves to DRAIN after TAIL_LEN zero bits have been encoded.
  - DRAIN moves to IDLE once the out_last bit is accepted.
- start in any state:
  - Discards all pending output bits.
  - Clears sr and phase, latches rate, enters RUN.
  - Forces in_ready=0 that cycle; start wins over a simultaneous in_valid.
- Encoding, with sr[0] the most recent past bit:
  - X = in^sr0^sr1^sr2^sr5 (G1=171 octal).
  - Y = in^sr1^sr2^sr4^sr5 (G2=133 octal).
  - Then sr = {sr[4:0], in}.
- Puncture masks, per phase 0..P-1:
  - 1/2: P=1, X=1, Y=1.
  - 2/3: P=2, X=10, Y=11.
  - 3/4: P=3, X=101, Y=110.
  - 5/6: P=5, X=10101, Y=11010.
- Every phase keeps at least one bit. Kept bits go into a 2-entry output buffer, ordered X before Y.
- phase increments per encoded bit and wraps at P-1 to 0. phase persists across the burst, including tail bits.
- Handshake:
  - in_ready = RUN && !start && (pending==0 || (pending==1 && out_valid && out_ready)).
  - Transfer occurs when in_valid && in_ready.
  - out_valid = pending>0. out_bits is the head of the buffer.
  - A pop on out_valid && out_ready and a push in the same cycle are both honoured.
  - out_bits and out_last hold stable while out_valid && !out_ready.
- Latency: the first coded bit of an accepted input appears on out_valid the next cycle.
- out_last is asserted on the last buffered bit produced by:
  - the final tail bit (with the macro), or
  - the in_last input bit (without it).
- in_valid outside RUN is ignored.
- Reset mid-burst: everything returns to the reset values; no out_last is emitted.

Optional Feature:
- Macro CONV_ZERO_TAIL_EN.
- Defined:
  - After the in_last bit, the encoder internally encodes TAIL_LEN zero bits with puncturing continuing.
  - in_ready=0 during TAIL.
  - sr ends at all-zero; out_last is on the final tail-derived bit.
- Undefined:
  - TAIL state and TAIL_LEN are unused; no flush occurs.
  - sr keeps its value until the next start.

Decomposition:
- Package conv_pkg holds:
  - rate encoding constants and G1/G2 constants;
  - puncture mask/period lookup per rate;
  - the state enum typedef.
- One sub-module, conv_core: combinational X/Y generation plus the sr register with a clear input.
- Top level holds the FSM, phase counter, output buffer and handshake.

Test Plan:
- Impulse response: rate 1/2, start, input 1,0,0,0,0,0,0 (last on 7th), out_ready=1.
  - Required output: 11 10 11 11 00 01 11 (X then Y per pair).
  - out_last on the 14th bit.
- Rate 3/4, input 1,1,1 with out_ready=1.
  - Outputs X1,Y1,Y2,X3, 4 bits for 3 inputs.
  - in_ready drops for one cycle after the first input.
  - phase returns to 0.
- Backpressure: rate 5/6, random out_ready at 30% duty over 200 random bits.
  - Output matches the reference model bit-exactly.
  - No loss or duplication; out_bits stable while stalled.
- Abort: start pulsed mid-burst with 2 bits pending and in_valid=1 the same cycle.
  - Pending bits dropped; the input bit is not accepted.
  - Next burst encodes from sr=0, phase=0.
- CONV_ZERO_TAIL_EN defined, rate 2/3, input single 1 with last.
  - 7 encoded bits (1+6 tail) produce 11 output bits.
  - out_last on the 11th; sr==0 afterwards.
- Reset held low for 1 cycle mid-burst.
  - All outputs 0 the next cycle; in_ready=0 until start.
